// File: rtl/bvand_ic_witness_gen.sv
// bvand_ic_witness_gen: bit-serial witness generator and invertibility-condition
// checker for x & s = t. Operands are scanned LSB-first, one bit per clock.
// The witness is x = t, ic_ok = (t & ~s == 0), and fail_cnt saturates at 255.
//
// Build option BVAND_IC_SELFCHECK_EN: adds a VERIFY pass that rechecks
// (x & s) == t bit by bit and drives sat from that recheck. Without it,
// sat simply mirrors ic_ok.
//
// state  | meaning
// IDLE   | in_ready=1, waiting for an (s, t) pair
// SCAN   | one operand bit per cycle: x[k] <= t[k], clear ic flag on t & ~s
// VERIFY | (option only) one bit per cycle: AND ((x & s) == t) into sat
// DONE   | out_valid=1, results held until out_ready
module bvand_ic_witness_gen #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_s,
  input  logic [W-1:0] i_t,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_x,
  output logic         o_ic_ok,
  output logic         o_sat,
  output logic [7:0]   o_fail_cnt
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [IW-1:0] LAST = IW'(W - 1);

`ifdef BVAND_IC_SELFCHECK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, VERIFY = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t        r_state;
  state_t        w_next;
  logic [W-1:0]  r_s;
  logic [W-1:0]  r_t;
  logic [W-1:0]  r_x;
  logic [IW-1:0] r_idx;
  logic          r_ic;
  logic          r_ic_ok;
  logic [7:0]    r_fail_cnt;
  logic          w_accept;
  logic          w_last;
  logic          w_bit_bad;
  logic          w_ic_next;
  logic          w_enter_done;
  logic          w_final_ic;

  assign w_accept  = (r_state == IDLE) & i_in_valid;
  assign w_last    = (r_idx == LAST);
  assign w_bit_bad = r_t[r_idx] & ~r_s[r_idx];
  assign w_ic_next = r_ic & ~w_bit_bad;

`ifdef BVAND_IC_SELFCHECK_EN
  logic r_sat;
  logic r_sat_out;
  logic w_chk_ok;
  logic w_sat_next;

  // Recheck uses the stored x and operands only, never the ic flag.
  assign w_chk_ok     = ((r_x[r_idx] & r_s[r_idx]) == r_t[r_idx]);
  assign w_sat_next   = r_sat & w_chk_ok;
  assign w_enter_done = (r_state == VERIFY) & w_last;
  assign w_final_ic   = r_ic;
  assign o_sat        = r_sat_out;
`else
  // ic flag for the last bit is folded in on the same edge that enters DONE.
  assign w_enter_done = (r_state == SCAN) & w_last;
  assign w_final_ic   = w_ic_next;
  assign o_sat        = r_ic_ok;
`endif

  assign o_x        = r_x;
  assign o_ic_ok    = r_ic_ok;
  assign o_fail_cnt = r_fail_cnt;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode and state-derived handshake outputs.
  always_comb begin
    w_next      = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        o_in_ready = 1'b1;
        if (i_in_valid) w_next = SCAN;
      end
      SCAN: begin
`ifdef BVAND_IC_SELFCHECK_EN
        if (w_last) w_next = VERIFY;
`else
        if (w_last) w_next = DONE;
`endif
      end
`ifdef BVAND_IC_SELFCHECK_EN
      VERIFY: begin
        if (w_last) w_next = DONE;
      end
`endif
      DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand capture and the per-bit scan/verify datapath.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s   <= '0;
      r_t   <= '0;
      r_x   <= '0;
      r_idx <= '0;
      r_ic  <= 1'b0;
`ifdef BVAND_IC_SELFCHECK_EN
      r_sat <= 1'b0;
`endif
    end else if (w_accept) begin
      r_s   <= i_s;
      r_t   <= i_t;
      r_x   <= '0;
      r_idx <= '0;
      r_ic  <= 1'b1;
`ifdef BVAND_IC_SELFCHECK_EN
      r_sat <= 1'b1;
`endif
    end else if (r_state == SCAN) begin
      r_x[r_idx] <= r_t[r_idx];
      r_ic       <= w_ic_next;
      r_idx      <= w_last ? '0 : r_idx + IW'(1);
`ifdef BVAND_IC_SELFCHECK_EN
    end else if (r_state == VERIFY) begin
      r_sat <= w_sat_next;
      r_idx <= w_last ? '0 : r_idx + IW'(1);
`endif
    end
  end

  // Result registers and saturating fail counter, loaded on entry to DONE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ic_ok    <= 1'b0;
      r_fail_cnt <= 8'd0;
`ifdef BVAND_IC_SELFCHECK_EN
      r_sat_out  <= 1'b0;
`endif
    end else if (w_enter_done) begin
      r_ic_ok <= w_final_ic;
`ifdef BVAND_IC_SELFCHECK_EN
      r_sat_out <= w_sat_next;
`endif
      if (!w_final_ic && (r_fail_cnt != 8'hFF)) r_fail_cnt <= r_fail_cnt + 8'd1;
    end
  end

endmodule
